axi4_lite_master: RTL and testbench
===================================

Name: axi4_lite_master

Overview:
- AXI4-Lite single-outstanding master that sits directly upstream of axi4_slave and drives its AW/W/B/AR/R channels.
- Converts a simple valid/ready command port (read or write, one beat) into the matching AXI4-Lite transaction.
- Returns read data and response code on a valid/ready response port.
- Used by CPU-side glue and test harnesses to reach the slave register file without hand-sequencing channel signals.

Parameters:
- ADDR_W, 32, address width of cmd_addr/AWADDR/ARADDR.
- DATA_W, 32, data width; STRB_W = DATA_W/8 is derived, not overridable.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_wstrb  in  STRB_W  write byte strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master-side directions and widths.

Behaviour:
- Reset: ARESETn sampled low at a rising edge returns the FSM to IDLE. In the same edge it clears every AXI valid/ready output, rsp_valid, rsp_rdata, rsp_resp and the aw_done/w_done flags. Address/data outputs reset to 0.
- cmd_ready = (state==IDLE) && ARESETn. It is 0 during reset.
- Reset mid-transaction abandons the transaction with no response generated. All valids drop in the reset cycle.
- FSM states are IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - A cmd_valid && cmd_ready handshake registers addr, wdata and wstrb.
  - Write: go to WR with AWVALID=WVALID=1 from the next cycle.
  - Read: go to RD_ADDR with ARVALID=1 from the next cycle.
- WR:
  - AW and W complete independently.
  - On AWVALID&&AWREADY, drop AWVALID and set aw_done. On WVALID&&WREADY, drop WVALID and set w_done. Both may complete in the same cycle.
  - Once both are done, go to WR_RESP. BREADY=1 from that next cycle.
  - BVALID seen while in WR is not accepted, because BREADY=0.
- WR_RESP: on BVALID&&BREADY, capture BRESP into rsp_resp, set rsp_rdata=0, drop BREADY and go to RSP.
- RD_ADDR: on ARREADY, drop ARVALID and go to RD_DATA with RREADY=1.
- RD_DATA: on RVALID&&RREADY, capture RDATA and RRESP, drop RREADY and go to RSP.
- RSP: rsp_valid=1 and the response outputs are held stable until rsp_ready. On that handshake go to IDLE. cmd_ready is high from the next cycle; commands are not accepted back-to-back with the response.
- AXI valid-stability rules hold: a raised AxVALID/WVALID never drops before its handshake, and its payload never changes while valid.
- Minimum latency, with an always-ready slave that returns its response one cycle after the handshake:
  - Write: command accept edge 0, AW/W handshake edge 1, B handshake edge 3, rsp_valid visible after edge 3.
  - Read: AR handshake edge 1, R handshake edge 3.
- Non-OKAY responses are passed through unchanged. No retry.

Optional Feature:
- AXI_MASTER_ERRCNT_EN defined:
  - Adds output err_count [15:0] and input err_clr [0:0].
  - err_count increments on every B or R handshake whose resp != 2'b00 and saturates at 16'hFFFF.
  - err_clr=1 clears it to 0; clear has priority over a simultaneous increment.
  - err_count resets to 0.
- Not defined: the ports and counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared package axi4_pkg holds:
  - The resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - The master FSM state enum.
  - Default ADDR_W/DATA_W localparams, shared with axi4_slave.
- No sub-module: the FSM and capture registers form one module. The error counter stays inline under the macro.

Test Plan:
- Write 0x00000004 / 0xDEADBEEF / wstrb 4'hF into axi4_slave → exactly one AW and one W handshake, then rsp_valid with rsp_resp=2'b00 and rsp_rdata=0.
- Read 0x00000004 after that write → ARADDR=0x4, rsp_rdata=0xDEADBEEF, rsp_resp=2'b00.
- Stub slave holds AWREADY low 3 cycles with WREADY high immediately → WVALID drops after 1 cycle, AWVALID holds 4 cycles, BREADY only after both, single response.
- Hold rsp_ready low 5 cycles after a read → rsp_valid, rsp_rdata and rsp_resp stay stable, cmd_ready=0 throughout, and a cmd_valid presented meanwhile is not accepted.
- Assert ARESETn low for one edge while AWVALID is pending → AWVALID/WVALID=0 in the next cycle, no rsp_valid, cmd_ready=1 once ARESETn is high; a following read works normally.
- AXI_MASTER_ERRCNT_EN: stub slave returns SLVERR on 2 writes and OKAY on 1 → err_count=2. Assert err_clr in the same cycle as a third SLVERR → err_count=0.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and default widths.
// Used by axi4_lite_master and axi4_slave.
package axi4_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } mst_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != 2'b00);
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one-beat command port in, response port out.
// Optional error counter (err_count/err_clr) enabled by defining AXI_MASTER_ERRCNT_EN.
module axi4_lite_master
  import axi4_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
`ifdef AXI_MASTER_ERRCNT_EN
  output logic [15:0]         err_count,
  input  logic                err_clr,
`endif
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;

  mst_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

  assign aw_hs_s = awvalid_q && AWREADY;
  assign w_hs_s  = wvalid_q  && WREADY;
  assign b_hs_s  = BVALID    && bready_q;
  assign ar_hs_s = arvalid_q && ARREADY;
  assign r_hs_s  = RVALID    && rready_q;

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        // AW and W retire independently; the write is issued once both have.
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else begin
          state_d = WR;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_ADDR: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (r_hs_s) begin
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          state_d = RD_DATA;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d     = IDLE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI_MASTER_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;
  logic        err_hit_s;

  assign err_hit_s = (b_hs_s && resp_is_err(BRESP)) || (r_hs_s && resp_is_err(RRESP));

  // Saturating error counter; a clear wins over a same-cycle error.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = 16'h0000;
    end else if (err_hit_s && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'h0001;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_count_q <= 16'h0000;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

  assign cmd_ready = (state_q == IDLE) && ARESETn;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = addr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = addr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed self-checking bench for axi4_lite_master with a small behavioural AXI4-Lite slave.
// Error-counter checks are compiled in when AXI_MASTER_ERRCNT_EN is defined.
module tb_axi4_lite_master;

  logic        ACLK;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
`ifdef AXI_MASTER_ERRCNT_EN
  logic [15:0] err_count;
  logic        err_clr;
`endif

  int checks = 0;
  int errors = 0;

  axi4_lite_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXI_MASTER_ERRCNT_EN
    .err_count(err_count), .err_clr(err_clr),
`endif
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [0:15];
  int          aw_stall = 0;
  int          aw_wait;
  logic [1:0]  bresp_val = 2'b00;
  logic [1:0]  rresp_val = 2'b00;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;

  logic        aw_hs, w_hs, aw_have, w_have;
  logic [31:0] cur_awaddr, cur_wdata;
  logic [3:0]  cur_wstrb;

  assign AWREADY    = (aw_wait >= aw_stall);
  assign WREADY     = 1'b1;
  assign ARREADY    = 1'b1;
  assign aw_hs      = AWVALID && AWREADY;
  assign w_hs       = WVALID && WREADY;
  assign aw_have    = aw_got || aw_hs;
  assign w_have     = w_got || w_hs;
  assign cur_awaddr = aw_hs ? AWADDR : s_awaddr;
  assign cur_wdata  = w_hs ? WDATA : s_wdata;
  assign cur_wstrb  = w_hs ? WSTRB : s_wstrb;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  always @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      BVALID <= 1'b0; RVALID <= 1'b0; BRESP <= 2'b00; RRESP <= 2'b00; RDATA <= 32'h0;
      s_awaddr <= 32'h0; s_wdata <= 32'h0; s_wstrb <= 4'h0; s_araddr <= 32'h0;
    end else begin
      if (AWVALID && !AWREADY) aw_wait <= aw_wait + 1;
      else if (aw_hs) aw_wait <= 0;
      if (aw_hs) begin aw_cnt <= aw_cnt + 1; s_awaddr <= AWADDR; end
      if (w_hs) begin w_cnt <= w_cnt + 1; s_wdata <= WDATA; s_wstrb <= WSTRB; end
      if (aw_have && w_have && !b_pend && !BVALID) begin
        mem[cur_awaddr[5:2]] <= merge(mem[cur_awaddr[5:2]], cur_wdata, cur_wstrb);
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs) w_got <= 1'b1;
      end
      if (b_pend) begin BVALID <= 1'b1; BRESP <= bresp_val; b_pend <= 1'b0; end
      else if (BVALID && BREADY) begin BVALID <= 1'b0; b_cnt <= b_cnt + 1; end
      if (ARVALID && ARREADY) begin r_pend <= 1'b1; s_araddr <= ARADDR; ar_cnt <= ar_cnt + 1; end
      if (r_pend) begin
        RVALID <= 1'b1; RDATA <= mem[s_araddr[5:2]]; RRESP <= rresp_val; r_pend <= 1'b0;
      end else if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    int n;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (!cmd_ready) begin
      errors++; $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge ACLK); #1; n++; end
    lat = n;
    checks++;
    if (!rsp_valid) begin
      errors++; $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
    end
  endtask

  task automatic consume();
    @(negedge ACLK); rsp_ready = 1'b1;
    @(posedge ACLK); #1; rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 0", cmd_ready); end
    checks++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_valids: got %b required 000000",
                         {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid});
    end
    checks++;
    if (AWADDR !== 32'h0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL reset_data: awaddr=%h rdata=%h resp=%b required 0", AWADDR, rsp_rdata, rsp_resp);
    end
    @(negedge ACLK); ARESETn = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b required 1", cmd_ready); end
  endtask

  task automatic test_write();
    int lat, aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (AWVALID !== 1'b1 || WVALID !== 1'b1 || AWADDR !== 32'h4 || WDATA !== 32'hDEADBEEF || WSTRB !== 4'hF) begin
      errors++; $display("FAIL write_issue: awv=%0b wv=%0b addr=%h data=%h strb=%h required 1 1 4 deadbeef f",
                         AWVALID, WVALID, AWADDR, WDATA, WSTRB);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL write_latency: got %0d required 3", lat); end
    checks++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL write_rsp: resp=%b rdata=%h required 00 0", rsp_resp, rsp_rdata);
    end
    checks++;
    if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1) begin
      errors++; $display("FAIL write_hs_count: aw=%0d w=%0d required 1 1", aw_cnt - aw0, w_cnt - w0);
    end
    consume();
  endtask

  task automatic test_read();
    int lat;
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    checks++;
    if (ARVALID !== 1'b1 || ARADDR !== 32'h4) begin
      errors++; $display("FAIL read_issue: arvalid=%0b araddr=%h required 1 4", ARVALID, ARADDR);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d required 3", lat); end
    checks++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL read_data: rdata=%h resp=%b required deadbeef 00", rsp_rdata, rsp_resp);
    end
    consume();
  endtask

  task automatic test_aw_stall();
    int aw_cyc, w_cyc, bad, n, b0;
    aw_stall = 3; b0 = b_cnt;
    issue(1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF);
    aw_cyc = 0; w_cyc = 0; bad = 0; n = 0;
    while (!rsp_valid && n < 30) begin
      if (AWVALID) aw_cyc++;
      if (WVALID) w_cyc++;
      if (BREADY && (AWVALID || WVALID)) bad++;
      @(posedge ACLK); #1; n++;
    end
    aw_stall = 0;
    checks++;
    if (aw_cyc != 4 || w_cyc != 1) begin
      errors++; $display("FAIL stall_valid_cycles: aw=%0d w=%0d required 4 1", aw_cyc, w_cyc);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_bready_early: got %0d required 0", bad); end
    checks++;
    if (n != 6 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL stall_latency: got %0d valid=%0b required 6 1", n, rsp_valid);
    end
    consume();
    checks++;
    if (b_cnt - b0 != 1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_single_rsp: b=%0d valid=%0b required 1 0", b_cnt - b0, rsp_valid);
    end
  endtask

  task automatic test_rsp_hold();
    int lat;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp(lat);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'hFFFF_0000; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_resp !== 2'b00) begin
        errors++; $display("FAIL hold_rsp[%0d]: valid=%0b rdata=%h resp=%b required 1 12345678 00",
                           i, rsp_valid, rsp_rdata, rsp_resp);
      end
      checks++;
      if (cmd_ready !== 1'b0 || AWVALID !== 1'b0 || ARVALID !== 1'b0) begin
        errors++; $display("FAIL hold_no_accept[%0d]: ready=%0b awv=%0b arv=%0b required 0 0 0",
                           i, cmd_ready, AWVALID, ARVALID);
      end
    end
    @(negedge ACLK); cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge ACLK); #1; rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || AWVALID !== 1'b0) begin
      errors++; $display("FAIL hold_release: valid=%0b ready=%0b awv=%0b required 0 1 0",
                         rsp_valid, cmd_ready, AWVALID);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    aw_stall = 10;
    issue(1'b1, 32'h0000_0010, 32'hAAAA_5555, 4'hF);
    checks++;
    if (AWVALID !== 1'b1) begin errors++; $display("FAIL midrst_pending: awv=%0b required 1", AWVALID); end
    @(negedge ACLK); ARESETn = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: awv=%0b wv=%0b rspv=%0b ready=%0b required 0 0 0 0",
                         AWVALID, WVALID, rsp_valid, cmd_ready);
    end
    @(negedge ACLK); ARESETn = 1'b1; aw_stall = 0; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b required 1", cmd_ready); end
    repeat (4) @(posedge ACLK);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || AWVALID !== 1'b0) begin
      errors++; $display("FAIL midrst_no_rsp: rspv=%0b awv=%0b required 0 0", rsp_valid, AWVALID);
    end
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL midrst_read: lat=%0d rdata=%h resp=%b required 3 deadbeef 00", lat, rsp_rdata, rsp_resp);
    end
    consume();
  endtask

`ifdef AXI_MASTER_ERRCNT_EN
  task automatic test_errcnt();
    int lat;
    logic [1:0] seq [3];
    seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      bresp_val = seq[i];
      issue(1'b1, 32'h0000_0020, 32'h0000_0001, 4'h1);
      wait_rsp(lat);
      checks++;
      if (rsp_resp !== seq[i]) begin errors++; $display("FAIL errcnt_resp[%0d]: got %b required %b", i, rsp_resp, seq[i]); end
      consume();
    end
    checks++;
    if (err_count !== 16'd2) begin errors++; $display("FAIL errcnt_two: got %0d required 2", err_count); end
    bresp_val = 2'b10;
    issue(1'b1, 32'h0000_0020, 32'h0000_0002, 4'h1);
    repeat (3) @(negedge ACLK);
    err_clr = 1'b1;
    @(posedge ACLK); #1; err_clr = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || err_count !== 16'd0) begin
      errors++; $display("FAIL errcnt_clr_priority: rspv=%0b count=%0d required 1 0", rsp_valid, err_count);
    end
    consume();
    bresp_val = 2'b00;
  endtask
`endif

  task automatic test_read_err();
    int lat;
    rresp_val = 2'b11;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (rsp_resp !== 2'b11 || rsp_rdata !== 32'h12345678) begin
      errors++; $display("FAIL read_decerr: resp=%b rdata=%h required 11 12345678", rsp_resp, rsp_rdata);
    end
    consume();
    rresp_val = 2'b00;
`ifdef AXI_MASTER_ERRCNT_EN
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL errcnt_read: got %0d required 1", err_count); end
`endif
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0; ARESETn = 1'b0;
`ifdef AXI_MASTER_ERRCNT_EN
    err_clr = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_aw_stall();
    test_rsp_hold();
    test_reset_mid();
`ifdef AXI_MASTER_ERRCNT_EN
    test_errcnt();
`endif
    test_read_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
